// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: accepts PC requests, reads a 1-cycle sync memory and
// returns tagged instructions in order through a response FIFO. Define IFR_BYPASS_EN for 1-cycle bypass.
module inst_fetch_resp #(
  parameter int MEM_AW     = 10,
  parameter int FIFO_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              flush,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_inst,
  output logic [31:0]       resp_addr,
  output logic              resp_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  logic              alive_r;
  logic              epoch_r;
  logic              inflight_r;
  logic              if_err_r;
  logic              if_epoch_r;
  logic [31:0]       if_addr_r;

  logic [31:0]       fifo_inst_r [FIFO_DEPTH];
  logic [31:0]       fifo_addr_r [FIFO_DEPTH];
  logic              fifo_err_r  [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  logic              fault_s;
  logic              accept_s;
  logic [CW:0]       credit_s;
  logic              arrive_s;
  logic [31:0]       arr_inst_s;
  logic              byp_s;
  logic              head_valid_s;
  logic              push_s;
  logic              pop_s;

  // Request acceptance, address check and memory read issue
  always_comb begin
    fault_s   = (req_addr[1:0] != 2'b00) || (req_addr[31:MEM_AW+2] != {(30-MEM_AW){1'b0}});
    credit_s  = (CW+1)'(count_r) + (CW+1)'(inflight_r);
    req_ready = alive_r && (credit_s < (CW+1)'(FIFO_DEPTH));
    accept_s  = req_valid && req_ready;
    mem_en    = accept_s && !fault_s;
    if (mem_en) begin
      mem_addr = req_addr[MEM_AW+1:2];
    end else begin
      mem_addr = {MEM_AW{1'b0}};
    end
  end

  // Arrival of read data (stale words from before a flush are dropped here)
  always_comb begin
    arrive_s     = inflight_r && !flush && (if_epoch_r == epoch_r);
    arr_inst_s   = if_err_r ? NOP_INST : mem_rdata;
    head_valid_s = (count_r != {CW{1'b0}});
`ifdef IFR_BYPASS_EN
    byp_s        = arrive_s && !head_valid_s;
`else
    byp_s        = 1'b0;
`endif
    pop_s        = head_valid_s && resp_ready;
    push_s       = arrive_s && !(byp_s && resp_ready);
  end

  // Response outputs from FIFO head, or the arriving word when bypassing
  always_comb begin
    resp_valid = 1'b0;
    resp_inst  = 32'h0000_0000;
    resp_addr  = 32'h0000_0000;
    resp_err   = 1'b0;
    if (head_valid_s) begin
      resp_valid = 1'b1;
      resp_inst  = fifo_inst_r[rd_ptr_r];
      resp_addr  = fifo_addr_r[rd_ptr_r];
      resp_err   = fifo_err_r[rd_ptr_r];
    end else if (byp_s) begin
      resp_valid = 1'b1;
      resp_inst  = arr_inst_s;
      resp_addr  = if_addr_r;
      resp_err   = if_err_r;
    end else begin
      resp_valid = 1'b0;
    end
  end

  // Liveness flag holding req_ready low until the first cycle after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_r <= 1'b0;
    end else begin
      alive_r <= 1'b1;
    end
  end

  // In-flight read tag; requests accepted during flush carry the new epoch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epoch_r    <= 1'b0;
      inflight_r <= 1'b0;
      if_err_r   <= 1'b0;
      if_epoch_r <= 1'b0;
      if_addr_r  <= 32'h0000_0000;
    end else begin
      epoch_r    <= flush ? ~epoch_r : epoch_r;
      inflight_r <= accept_s;
      if (accept_s) begin
        if_err_r   <= fault_s;
        if_epoch_r <= flush ? ~epoch_r : epoch_r;
        if_addr_r  <= req_addr;
      end else begin
        if_err_r   <= if_err_r;
        if_epoch_r <= if_epoch_r;
        if_addr_r  <= if_addr_r;
      end
    end
  end

  // FIFO entry storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst_r[i] <= 32'h0000_0000;
        fifo_addr_r[i] <= 32'h0000_0000;
        fifo_err_r[i]  <= 1'b0;
      end
    end else if (push_s) begin
      fifo_inst_r[wr_ptr_r] <= arr_inst_s;
      fifo_addr_r[wr_ptr_r] <= if_addr_r;
      fifo_err_r[wr_ptr_r]  <= if_err_r;
    end
  end

  // FIFO pointers and occupancy; the credit check guarantees push never sees a full FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed self-checking bench for inst_fetch_resp with a 1-cycle synchronous memory model.
module tb_inst_fetch_resp;

  localparam int MEM_AW     = 10;
  localparam int FIFO_DEPTH = 3;
`ifdef IFR_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_addr = 32'h0;
  logic              flush = 1'b0;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata = 32'h0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_inst;
  logic [31:0]       resp_addr;
  logic              resp_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
    int          c;
  } rsp_t;
  rsp_t q[$];

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  inst_fetch_resp #(.MEM_AW(MEM_AW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_inst(resp_inst), .resp_addr(resp_addr), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (rst && resp_valid && resp_ready) begin
      q.push_back('{inst: resp_inst, addr: resp_addr, err: resp_err, c: cyc});
    end
  end

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h0050_0093;
    return 32'hA000_0000 | (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic exp_mem, output int acc);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    acc = -1;
    req_valid = 1'b1;
    req_addr = a;
    while (!got && n < 20) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        acc = cyc;
        chk("mem_en", 32'(mem_en), 32'(exp_mem));
        if (exp_mem) chk("mem_addr", 32'(mem_addr), 32'(a[11:2]));
      end
      step();
      n++;
    end
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic chk_rsp(input int i, input logic [31:0] a, input logic [31:0] inst,
                         input logic err, input int exp_c);
    if (i < q.size()) begin
      chk("rsp_addr", q[i].addr, a);
      chk("rsp_inst", q[i].inst, inst);
      chk("rsp_err", 32'(q[i].err), 32'(err));
      if (exp_c >= 0) chk("rsp_cycle", 32'(q[i].c), 32'(exp_c));
    end else begin
      chk("rsp_count", 32'(q.size()), 32'(i + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2;
    int acc [4];
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = memw(32'(i) << 2);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_inst", resp_inst, 32'h0);
    chk("rst_resp_addr", resp_addr, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    step();

    // single request to word 2
    resp_ready = 1'b1;
    q.delete();
    send(32'h8, 1'b1, a0);
    repeat (6) step();
    chk("t1_count", 32'(q.size()), 32'd1);
    chk_rsp(0, 32'h8, 32'h0050_0093, 1'b0, a0 + LAT);

    // back-to-back with consumer ready
    q.delete();
    for (int i = 0; i < 4; i++) send(32'(i * 4), 1'b1, acc[i]);
    repeat (8) step();
    for (int i = 1; i < 4; i++) chk("t2_b2b_accept", 32'(acc[i]), 32'(acc[0] + i));
    chk("t2_count", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_rsp(i, 32'(i * 4), memw(32'(i * 4)), 1'b0, acc[0] + i + LAT);

    // backpressure: credits run out after three accepts
    resp_ready = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) send(32'(i * 4), 1'b1, acc[i]);
    req_valid = 1'b1;
    req_addr = 32'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_ready_low", 32'(req_ready), 32'd0);
      chk("t3_head_valid", 32'(resp_valid), 32'd1);
      chk("t3_head_stable", resp_addr, 32'h0);
      step();
    end
    resp_ready = 1'b1;
    send(32'hC, 1'b1, a0);
    repeat (8) step();
    chk("t3_count", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_rsp(i, 32'(i * 4), memw(32'(i * 4)), 1'b0, -1);

    // faulting addresses: misaligned and out of range
    q.delete();
    send(32'h6, 1'b0, a0);
    send(32'h1000, 1'b0, a1);
    repeat (6) step();
    chk("t4_count", 32'(q.size()), 32'd2);
    chk_rsp(0, 32'h6, NOP, 1'b1, a0 + LAT);
    chk_rsp(1, 32'h1000, NOP, 1'b1, a1 + LAT);

    // flush with a same-cycle new-stream request
    resp_ready = 1'b0;
    q.delete();
    send(32'h10, 1'b1, a0);
    send(32'h14, 1'b1, a1);
    flush = 1'b1;
    send(32'h40, 1'b1, a2);
    flush = 1'b0;
    @(negedge clk);
    chk("t5_valid_after_flush", 32'(resp_valid), 32'(LAT == 1));
    step();
    resp_ready = 1'b1;
    repeat (6) step();
    chk("t5_count", 32'(q.size()), 32'd1);
    chk_rsp(0, 32'h40, memw(32'h40), 1'b0, -1);

    // reset mid-stream: two buffered, one in flight
    resp_ready = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) send(32'(i * 4), 1'b1, acc[i]);
    req_valid = 1'b1;
    req_addr = 32'h4;
    rst = 1'b0;
    #1;
    chk("t6_resp_valid", 32'(resp_valid), 32'd0);
    chk("t6_resp_inst", resp_inst, 32'h0);
    chk("t6_resp_addr", resp_addr, 32'h0);
    chk("t6_resp_err", 32'(resp_err), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    chk("t6_mem_en", 32'(mem_en), 32'd0);
    req_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    resp_ready = 1'b1;
    repeat (4) step();
    chk("t6_no_stale", 32'(q.size()), 32'd0);
    send(32'h0, 1'b1, a0);
    repeat (6) step();
    chk("t6_count", 32'(q.size()), 32'd1);
    chk_rsp(0, 32'h0, memw(32'h0), 1'b0, a0 + LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_resp.md
Name: inst_fetch_resp

Overview:
- Responder side of the instruction-fetch interface.
- Accepts fetch addresses from the program counter over a valid/ready handshake and reads a synchronous instruction memory with 1-cycle read latency.
- Returns each instruction, tagged with its address, through an in-order response FIFO.
- Supports flush on control-flow change, so the PC can redirect without stale instructions reaching decode.

Parameters:
- MEM_AW, 10, word-address width of the instruction memory (memory holds 2^MEM_AW 32-bit words).
- FIFO_DEPTH, 3, response FIFO entries; minimum 2. Default 3 sustains one fetch per cycle.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  PC presents a fetch address.
- req_ready  out  1  block can accept a request this cycle.
- req_addr  in  32  byte address of instruction.
- flush  in  1  discard all in-flight and buffered responses.
- mem_en  out  1  memory read enable.
- mem_addr  out  MEM_AW  memory word address.
- mem_rdata  in  32  read data, valid the cycle after mem_en.
- resp_valid  out  1  response available.
- resp_ready  in  1  decode accepts response.
- resp_inst  out  32  instruction word.
- resp_addr  out  32  byte address the instruction came from.
- resp_err  out  1  fetch fault flag (misaligned or out of range).

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO empty; in-flight flag clear.
  - req_ready=0 while rst is low, then 1 from the first cycle after release.
  - resp_valid=0, resp_inst=0, resp_addr=0, resp_err=0, mem_en=0, mem_addr=0.
  - A read in flight when reset asserts is lost; no response is produced for it.
- Accept rule:
  - A request is accepted when req_valid && req_ready.
  - req_ready = (fifo_count + inflight) < FIFO_DEPTH.
  - req_ready is registered-state only; there is no combinational path from resp_ready.
- Address check:
  - Fault when req_addr[1:0]!=0 or req_addr[31:MEM_AW+2]!=0.
  - Faulting request: mem_en=0, inflight still set. Next cycle the block pushes inst=32'h00000013 (NOP) with err=1, in order.
- Normal request:
  - mem_en=1, mem_addr=req_addr[MEM_AW+1:2] combinationally in the accept cycle.
  - The address is latched as a tag.
- Latency:
  - Accept in cycle N; mem_rdata sampled at end of N+1 and pushed with its tag.
  - resp_valid high in N+2 (without bypass).
- Output handshake:
  - resp_* driven from the FIFO head.
  - Pop on resp_valid && resp_ready.
  - resp_* stable while resp_valid && !resp_ready.
- Simultaneous push and pop: permitted; count unchanged.
- Flush:
  - Synchronous.
  - Clears the FIFO and marks any in-flight read stale via an epoch bit; stale data is dropped on arrival and never pushed.
  - A request accepted in the same cycle as flush belongs to the new stream and is kept.
  - resp_valid=0 the cycle after flush unless bypass forwards a new-stream word.
- Ordering: responses strictly in request order; no reordering or duplication.
- Credit invariant: fifo_count + inflight <= FIFO_DEPTH at all times, so a push never finds the FIFO full.

Optional Feature:
- IFR_BYPASS_EN defined:
  - When the FIFO is empty, the arriving non-stale mem_rdata (or fault NOP) drives resp_* combinationally in cycle N+1 with resp_valid=1.
  - If resp_ready=1 the word is consumed without a push; otherwise it is pushed.
  - Latency is 1 cycle.
- Undefined: all responses pass through the FIFO; latency is 2 cycles.

Test Plan:
- Release reset, single request req_addr=0x00000008, memory word 2=0x00500093, resp_ready=1 -> resp_valid at N+2 (N+1 with IFR_BYPASS_EN), resp_inst=0x00500093, resp_addr=0x8, resp_err=0.
- Back-to-back requests 0x0,0x4,0x8,0xC with resp_ready=1, FIFO_DEPTH=3 -> req_ready stays 1; four responses on consecutive cycles, in order, matching memory.
- Same four requests with resp_ready=0 -> req_ready drops after 3 accepts. Raise resp_ready -> responses for 0x0,0x4,0x8 drain in order, 0xC is then accepted and returned; no loss.
- req_addr=0x00000006, then 0x00001000 with MEM_AW=10 -> no mem_en for either; two responses inst=0x00000013, resp_err=1, resp_addr 0x6 and 0x1000.
- Accept 0x10, 0x14, then assert flush with a new request 0x40 in the same cycle as 0x14's data returns -> no responses for 0x10/0x14; next response is 0x40 with correct data.
- Assert rst low mid-stream with 2 FIFO entries and 1 in flight -> all outputs 0 immediately; after release, no stale response appears and request 0x0 completes normally.
